// File: rtl/logicap_pkg.sv
// Shared types and constants for the capture datapath blocks.
package logicap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_FINISH
  } framer_state_t;

  localparam int BURST_LEN_DEF = 16;
  localparam int BCNT_W_DEF    = $clog2(BURST_LEN_DEF);

  // Width of a counter that indexes beats inside one burst.
  function automatic int bcnt_width(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-Stream skid register: registered s_ready and m_valid,
// one cycle of latency, full throughput while m_ready stays high.
module axis_skid #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [DATA_W-1:0] skid_data_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] out_data_p1;
  logic              vld_p1;

  // The skid slot only fills while the output is stalled, so an empty
  // slot is the whole ready condition.
  assign s_ready = ~vld_p0;
  assign m_data  = out_data_p1;
  assign m_valid = vld_p1;

  // Stage p0 -> p1: refill the output from the skid slot first, then from
  // the input; park the input in the skid slot when the output is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_data_p0 <= '0;
      vld_p0       <= 1'b0;
      out_data_p1  <= '0;
      vld_p1       <= 1'b0;
    end else if (!vld_p1 || m_ready) begin
      if (vld_p0) begin
        out_data_p1 <= skid_data_p0;
        vld_p1      <= 1'b1;
        vld_p0      <= 1'b0;
      end else if (s_valid) begin
        out_data_p1 <= s_data;
        vld_p1      <= 1'b1;
      end else begin
        vld_p1      <= 1'b0;
      end
    end else if (s_valid && !vld_p0) begin
      skid_data_p0 <= s_data;
      vld_p0       <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_burst_framer.sv
// Regroups one capture of samples into fixed-length DMA bursts, padding
// the open burst on abort, and reports progress/completion.
module axis_burst_framer
  import logicap_pkg::*;
#(
  parameter int dataw     = 32,
  parameter int saddr_w   = 24,
  parameter int burst_len = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [saddr_w-1:0] total_count,
  input  logic               abort,
  input  logic [dataw-1:0]   pad_word,
  input  logic [dataw-1:0]   slave_tdata,
  input  logic               slave_tvalid,
  output logic               slave_tready,
  output logic [dataw-1:0]   master_tdata,
  output logic               master_tvalid,
  output logic               master_tlast,
  input  logic               master_tready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [saddr_w-1:0] beats_sent
);

  localparam int              BCNT_W   = bcnt_width(burst_len);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(burst_len - 1);

  framer_state_t      state, state_nxt;
  logic [saddr_w-1:0] total_q, acc_cnt, acc_nxt, beats_sent_q, beats_sent_nxt;
  logic [BCNT_W-1:0]  bcnt, in_pos;
  logic               abort_pend, pad_last_in, aborted_q;
  logic               slave_hs, master_hs, abort_take;
  logic               sk_in_valid, sk_ready, sk_push, sk_empty, in_last;
  logic [dataw:0]     sk_in_data, sk_out_data;

  // Built only from registers, so it never follows master_tready.
  assign slave_tready = (state == ST_STREAM) && !abort_pend && sk_ready &&
                        (acc_cnt < total_q);
  assign slave_hs     = slave_tvalid && slave_tready;
  assign master_hs    = master_tvalid && master_tready;
  assign acc_nxt      = acc_cnt + saddr_w'(slave_hs);
  assign sk_push      = sk_in_valid && sk_ready;
  assign sk_empty     = sk_ready && !master_tvalid;

  // An abort that lands with the final sample is just a normal finish.
  assign abort_take = abort && (state == ST_STREAM) && !abort_pend &&
                      (acc_nxt != total_q);

  assign beats_sent_nxt = (master_hs && state == ST_STREAM && beats_sent_q != total_q)
                          ? beats_sent_q + 1'b1 : beats_sent_q;

  assign busy         = (state == ST_STREAM) || (state == ST_PAD);
  assign done         = (state == ST_FINISH);
  assign aborted      = aborted_q;
  assign beats_sent   = beats_sent_q;
  assign master_tdata = sk_out_data[dataw-1:0];
  assign master_tlast = sk_out_data[dataw];

  // Select what feeds the skid: live samples while streaming, pad beats
  // afterwards. tlast is decided here from the input-side burst position.
  always_comb begin
    sk_in_valid = 1'b0;
    in_last     = 1'b0;
    sk_in_data  = '0;
    if (state == ST_PAD) begin
      sk_in_valid = !pad_last_in;
      in_last     = (in_pos == BCNT_MAX);
      sk_in_data  = {in_last, pad_word};
    end else begin
      sk_in_valid = slave_hs;
      in_last     = (in_pos == BCNT_MAX) || (acc_cnt == total_q - 1'b1);
      sk_in_data  = {in_last, slave_tdata};
    end
  end

  axis_skid #(
    .DATA_W (dataw + 1)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .s_data  (sk_in_data),
    .s_valid (sk_in_valid),
    .s_ready (sk_ready),
    .m_data  (sk_out_data),
    .m_valid (master_tvalid),
    .m_ready (master_tready)
  );

  // Next-state logic. A zero-length capture spends one cycle in STREAM,
  // which is what makes its done pulse land two cycles after start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (beats_sent_nxt == total_q)     state_nxt = ST_FINISH;
        else if (abort_pend && sk_empty)   state_nxt = (bcnt == '0) ? ST_FINISH : ST_PAD;
      end
      ST_PAD:    if (master_hs && master_tlast) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Transfer counters and abort/pad bookkeeping, cleared by an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_q      <= '0;
      acc_cnt      <= '0;
      beats_sent_q <= '0;
      bcnt         <= '0;
      in_pos       <= '0;
      abort_pend   <= 1'b0;
      pad_last_in  <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      total_q      <= total_count;
      acc_cnt      <= '0;
      beats_sent_q <= '0;
      bcnt         <= '0;
      in_pos       <= '0;
      abort_pend   <= 1'b0;
      pad_last_in  <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      acc_cnt      <= acc_nxt;
      beats_sent_q <= beats_sent_nxt;
      if (master_hs) bcnt <= master_tlast ? '0 : bcnt + 1'b1;
      if (sk_push)   in_pos <= in_last ? '0 : in_pos + 1'b1;
      if (abort_take) begin
        abort_pend <= 1'b1;
        aborted_q  <= 1'b1;
      end
      if (state == ST_PAD && sk_push && in_last) pad_last_in <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_burst_framer.sv
// Randomized bench for axis_burst_framer with a queue-based reference model.
module tb_axis_burst_framer;

  localparam int DW = 32;
  localparam int AW = 24;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start, abort;
  logic [AW-1:0] total_count;
  logic [DW-1:0] pad_word, slave_tdata, master_tdata;
  logic          slave_tvalid, slave_tready;
  logic          master_tvalid, master_tlast, master_tready;
  logic          busy, done, aborted;
  logic [AW-1:0] beats_sent;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  axis_burst_framer #(.dataw(DW), .saddr_w(AW), .burst_len(BL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .total_count(total_count),
    .abort(abort), .pad_word(pad_word), .slave_tdata(slave_tdata),
    .slave_tvalid(slave_tvalid), .slave_tready(slave_tready),
    .master_tdata(master_tdata), .master_tvalid(master_tvalid),
    .master_tlast(master_tlast), .master_tready(master_tready),
    .busy(busy), .done(done), .aborted(aborted), .beats_sent(beats_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk_eq({pfx, "_slave_tready"},  slave_tready,  0);
    chk_eq({pfx, "_master_tvalid"}, master_tvalid, 0);
    chk_eq({pfx, "_master_tlast"},  master_tlast,  0);
    chk_eq({pfx, "_master_tdata"},  master_tdata,  0);
    chk_eq({pfx, "_busy"},          busy,          0);
    chk_eq({pfx, "_done"},          done,          0);
    chk_eq({pfx, "_aborted"},       aborted,       0);
    chk_eq({pfx, "_beats_sent"},    beats_sent,    0);
  endtask

  // One capture: drive random traffic, record both handshake streams, then
  // compare against the burst/pad rules computed from the accepted samples.
  task automatic run_xfer(input int total, input int rdy_pct, input int vld_pct,
                          input int abort_at, input bit abort_hold, input bit start_mid);
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] out_d[$];
    bit            out_l[$];
    int  acc = 0, acc_ab = 0, pads, start_cyc, done_cyc = -1, last_m_cyc = -1;
    bit  abort_done = 0, exp_ab = 0, s_hs = 0, s_hs_prev = 0, m_hs, can_send;
    bit  prev_stall = 0, prev_l = 0;
    logic [DW-1:0] prev_d = '0, exp_d;
    bit  exp_l;

    repeat (2) @(negedge clk);
    pad_word     = $urandom();
    total_count  = AW'(total);
    start        = 1'b1;
    slave_tvalid = 1'b0;
    master_tready = 1'b0;
    start_cyc    = cyc;

    for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (t == 0) chk_eq("busy_after_start", busy, 1);
      if (prev_stall) begin
        chk_eq("hold_tvalid", master_tvalid, 1);
        chk_eq("hold_tdata",  master_tdata,  prev_d);
        chk_eq("hold_tlast",  master_tlast,  prev_l);
      end
      if (done) begin
        done_cyc = cyc;
        chk_eq("busy_at_done", busy, 0);
        break;
      end
      master_tready = ($urandom_range(99) < rdy_pct);
      if (s_hs_prev || !slave_tvalid) begin
        can_send     = !(abort_hold && abort_at >= 0 && acc >= abort_at);
        slave_tdata  = $urandom();
        slave_tvalid = can_send && ($urandom_range(99) < vld_pct);
      end
      s_hs = slave_tvalid && slave_tready;
      if (s_hs) begin
        acc_q.push_back(slave_tdata);
        acc++;
      end
      m_hs = master_tvalid && master_tready;
      if (m_hs) begin
        out_d.push_back(master_tdata);
        out_l.push_back(master_tlast);
        last_m_cyc = cyc;
      end
      if (abort_at >= 0 && !abort_done && acc >= abort_at &&
          (!abort_hold || out_d.size() >= abort_at)) begin
        abort      = 1'b1;
        abort_done = 1;
        exp_ab     = (acc < total);
        acc_ab     = acc;
      end
      if (start_mid && t == 7) begin
        start       = 1'b1;
        total_count = AW'(total + 5);
      end
      prev_stall = master_tvalid && !master_tready;
      prev_d     = master_tdata;
      prev_l     = master_tlast;
      s_hs_prev  = s_hs;
    end
    slave_tvalid  = 1'b0;
    master_tready = 1'b0;
    abort         = 1'b0;
    start         = 1'b0;

    if (done_cyc < 0) chk_eq("done_timeout", 0, 1);
    if (exp_ab) chk_eq("accept_after_abort", acc, acc_ab);
    else        chk_eq("accepted_count", acc, total);
    pads = exp_ab ? (BL - acc % BL) % BL : 0;
    chk_eq("beat_count", out_d.size(), acc + pads);
    for (int i = 0; i < out_d.size() && i < acc + pads; i++) begin
      exp_d = (i < acc) ? acc_q[i] : pad_word;
      exp_l = (i % BL == BL - 1) || (i < acc && i == total - 1);
      chk_eq($sformatf("beat%0d_data", i), out_d[i], exp_d);
      chk_eq($sformatf("beat%0d_last", i), out_l[i], exp_l);
    end
    chk_eq("beats_sent", beats_sent, acc);
    chk_eq("aborted", aborted, exp_ab);
    if (total == 0)             chk_eq("done_latency_zero", done_cyc - start_cyc, 2);
    else if (!exp_ab || pads > 0) chk_eq("done_latency", done_cyc - last_m_cyc, 1);
  endtask

  initial begin
    resetn        = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    total_count   = '0;
    pad_word      = '0;
    slave_tdata   = '0;
    slave_tvalid  = 1'b0;
    master_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    resetn = 1'b1;

    run_xfer(48,  100, 100, -1, 0, 0);
    run_xfer(20,  100, 100, -1, 0, 0);
    run_xfer(40,  100, 100, 21, 1, 0);
    run_xfer(40,  100, 100, 16, 1, 0);
    run_xfer(100,  50,  70, -1, 0, 1);
    run_xfer(0,   100, 100, -1, 0, 0);
    run_xfer(30,  100, 100, 30, 0, 0);
    for (int k = 0; k < 4; k++)
      run_xfer($urandom_range(80, 1), $urandom_range(100, 30), $urandom_range(100, 40),
               (k % 2) ? int'($urandom_range(70, 1)) : -1, 0, 0);

    // Reset in the middle of a burst, then a clean capture.
    @(negedge clk);
    total_count = AW'(48);
    start       = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    slave_tvalid  = 1'b1;
    slave_tdata   = 32'h1234_5678;
    master_tready = 1'b1;
    repeat (20) @(negedge clk);
    chk_eq("busy_before_reset", busy, 1);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("midrst");
    slave_tvalid  = 1'b0;
    master_tready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_xfer(48, 100, 100, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
